// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style interrupt controller: handshake states,
// IR count and the fully-nested priority helper used by resolver and ISR logic.
`timescale 1ns/1ps
package pic_pkg;

   localparam int         NUM_IR       = 8;
   localparam logic [2:0] SPURIOUS_LVL = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      ACK1,
      WAIT1,
      WAIT2,
      ACK2
   } pic_state_t;

   // Lowest set index wins; 8 means nothing is set.
   function automatic logic [3:0] hp_index(input logic [NUM_IR-1:0] bits);
      hp_index = 4'd8;
      for (int i = NUM_IR - 1; i >= 0; i--) begin
         if (bits[i]) hp_index = 4'(i);
      end
   endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// Synchronises the asynchronous inta_n strobe into clk and flags its edges.
`timescale 1ns/1ps
module pic_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_n,
   output logic fall,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // NOTE: clocked state uses non-blocking assignments so every stage samples the
   // value from before the edge; blocking here would collapse the chain to one flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q[0] <= async_n;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign fall = prev_q & ~sync_q[STAGES-1];
   assign rise = ~prev_q & sync_q[STAGES-1];

endmodule

// File: rtl/isr_inta_controller.sv
// In-Service Register, INT output and 8086-mode two-pulse INTA handshake with
// vector drive; handles specific, non-specific and automatic EOI.
`timescale 1ns/1ps
module isr_inta_controller
   import pic_pkg::*;
#(
   parameter int INTA_SYNC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  irr_pending,
   input  logic [2:0]  chosen_interrupt,
   input  logic        inta_n,
   input  logic [4:0]  vector_base,
   input  logic        aeoi_en,
   input  logic        eoi_valid,
   input  logic        eoi_specific,
   input  logic [2:0]  eoi_level,
   output logic        int_out,
   output logic [7:0]  isr,
   output logic        clear_irr,
   output logic [2:0]  clear_irr_idx,
   output logic [7:0]  data_out,
   output logic        data_out_en
);

   pic_state_t state, state_nxt;
   logic       fall, rise;
   logic [2:0] lvl;
   logic       spurious;
   logic [3:0] hp_isr;
   logic       ack_hit;
   logic [7:0] isr_nxt;

   pic_sync_edge #(.STAGES(INTA_SYNC)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_n (inta_n),
      .fall    (fall),
      .rise    (rise)
   );

   assign hp_isr  = hp_index(isr);
   assign ack_hit = irr_pending[chosen_interrupt];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every comb output gets a default first so no path leaves it unassigned
   // (an unassigned path would infer a latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (fall) state_nxt = ACK1;
         ACK1:    state_nxt = WAIT1;
         WAIT1:   if (rise) state_nxt = WAIT2;
         WAIT2:   if (fall) state_nxt = ACK2;
         ACK2:    if (rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      clear_irr     = (state == ACK1) && ack_hit;
      clear_irr_idx = clear_irr ? chosen_interrupt : 3'd0;
      data_out_en   = (state == ACK2) && !rise;
      data_out      = data_out_en ? {vector_base, lvl} : 8'h00;
   end

   // EOI clears are applied before the acknowledge set, so a set of the same bit wins.
   always_comb begin
      isr_nxt = isr;
      if (eoi_valid) begin
         if (eoi_specific)  isr_nxt[eoi_level]   = 1'b0;
         else if (!hp_isr[3]) isr_nxt[hp_isr[2:0]] = 1'b0;
      end
      if ((state == ACK2) && rise && aeoi_en && !spurious) isr_nxt[lvl] = 1'b0;
      if ((state == ACK1) && ack_hit) isr_nxt[chosen_interrupt] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isr      <= 8'h00;
         int_out  <= 1'b0;
         lvl      <= 3'd0;
         spurious <= 1'b0;
      end else begin
         isr     <= isr_nxt;
         int_out <= (irr_pending != 8'h00) && ({1'b0, chosen_interrupt} < hp_isr)
                    && (state == IDLE) && !fall;
         if (state == ACK1) begin
            lvl      <= ack_hit ? chosen_interrupt : SPURIOUS_LVL;
            spurious <= !ack_hit;
         end
      end
   end

endmodule

// File: tb/tb_isr_inta_controller.sv
// Directed bench for isr_inta_controller: handshake sequences plus a vector table
// for priority gating of int_out and EOI handling.
`timescale 1ns/1ps
module tb_isr_inta_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irr_pending;
   logic [2:0] chosen_interrupt;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       aeoi_en;
   logic       eoi_valid;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       int_out;
   logic [7:0] isr;
   logic       clear_irr;
   logic [2:0] clear_irr_idx;
   logic [7:0] data_out;
   logic       data_out_en;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   isr_inta_controller #(.INTA_SYNC(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .irr_pending      (irr_pending),
      .chosen_interrupt (chosen_interrupt),
      .inta_n           (inta_n),
      .vector_base      (vector_base),
      .aeoi_en          (aeoi_en),
      .eoi_valid        (eoi_valid),
      .eoi_specific     (eoi_specific),
      .eoi_level        (eoi_level),
      .int_out          (int_out),
      .isr              (isr),
      .clear_irr        (clear_irr),
      .clear_irr_idx    (clear_irr_idx),
      .data_out         (data_out),
      .data_out_en      (data_out_en)
   );

   typedef struct {
      logic [7:0] irr;
      logic [2:0] ch;
      logic       eoi;
      logic       spec;
      logic [2:0] elvl;
      logic       exp_int;
      logic [7:0] exp_isr;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One INTA pulse: 6 cycles low, 6 high, observing outputs at each negedge.
   task automatic inta_pulse(output logic saw_en, output logic [7:0] dat,
                             output int clr_cnt, output logic [2:0] clr_idx,
                             output int leak);
      saw_en = 1'b0; dat = 8'h00; clr_cnt = 0; clr_idx = 3'd0; leak = 0;
      inta_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i == 6) inta_n = 1'b1;
         @(negedge clk);
         if (data_out_en) begin
            saw_en = 1'b1;
            dat    = data_out;
         end else if (data_out != 8'h00) begin
            leak++;
         end
         if (clear_irr) begin
            clr_cnt++;
            clr_idx = clear_irr_idx;
         end
      end
   endtask

   task automatic send_eoi(input logic spec, input logic [2:0] lv);
      eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lv;
      @(negedge clk);
      eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
      @(negedge clk);
   endtask

   task automatic request(input logic [7:0] irr, input logic [2:0] ch);
      irr_pending = irr; chosen_interrupt = ch;
      @(negedge clk);
   endtask

   logic       en;
   logic [7:0] dat;
   int         clr_cnt;
   logic [2:0] clr_idx;
   int         leak;

   initial begin
      rst_n = 1'b0; irr_pending = 8'h00; chosen_interrupt = 3'd0; inta_n = 1'b1;
      vector_base = 5'h10; aeoi_en = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0;
      eoi_level = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_int", int_out, 0);
      check("rst_isr", isr, 0);
      check("rst_clr", clear_irr, 0);
      check("rst_en",  data_out_en, 0);
      check("rst_data", data_out, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Plain acknowledge of IR3
      irr_pending = 8'h08; chosen_interrupt = 3'd3;
      check("p1_int_before", int_out, 0);
      @(negedge clk);
      check("p1_int_latency", int_out, 1);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      irr_pending = 8'h00;
      check("p1_pulse1_no_drive", en, 0);
      check("p1_clr_count", clr_cnt, 1);
      check("p1_clr_idx", clr_idx, 3);
      check("p1_int_after_fall", int_out, 0);
      check("p1_isr_between", isr, 8'h08);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      check("p1_pulse2_drive", en, 1);
      check("p1_vector", dat, 8'h83);
      check("p1_no_leak", leak, 0);
      check("p1_isr_after", isr, 8'h08);

      // Non-specific EOI
      send_eoi(1'b0, 3'd0);
      check("p2_isr", isr, 8'h00);
      check("p2_int", int_out, 0);

      // AEOI
      aeoi_en = 1'b1;
      request(8'h08, 3'd3);
      check("p3_int", int_out, 1);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      irr_pending = 8'h00;
      check("p3_isr_between", isr, 8'h08);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      check("p3_vector", dat, 8'h83);
      check("p3_isr_after", isr, 8'h00);
      aeoi_en = 1'b0;

      // Nesting under IR3
      request(8'h08, 3'd3);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      irr_pending = 8'h00;
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      check("p4_isr_ir3", isr, 8'h08);
      request(8'h20, 3'd5);
      @(negedge clk);
      check("p4_ir5_blocked", int_out, 0);
      request(8'h02, 3'd1);
      check("p4_ir1_allowed", int_out, 1);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      irr_pending = 8'h00;
      check("p4_clr_idx", clr_idx, 1);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      check("p4_vector", dat, 8'h81);
      check("p4_isr_nested", isr, 8'h0A);
      send_eoi(1'b1, 3'd1);
      check("p4_isr_spec_eoi", isr, 8'h08);

      // Spurious acknowledge: request vanishes before the first fall (AEOI on must not clear)
      aeoi_en = 1'b1;
      request(8'h08, 3'd3);
      irr_pending = 8'h00;
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      check("p5_no_clr", clr_cnt, 0);
      check("p5_isr_between", isr, 8'h08);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      check("p5_drive", en, 1);
      check("p5_vector", dat, 8'h87);
      check("p5_isr_after", isr, 8'h08);
      aeoi_en = 1'b0;

      // Reset during WAIT2
      request(8'h02, 3'd1);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      irr_pending = 8'h00;
      check("p6_isr_pre", isr, 8'h0A);
      #2 rst_n = 1'b0;
      #1;
      check("p6_rst_isr", isr, 0);
      check("p6_rst_int", int_out, 0);
      check("p6_rst_en", data_out_en, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      request(8'h08, 3'd3);
      check("p6_int", int_out, 1);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      irr_pending = 8'h00;
      check("p6_first_no_drive", en, 0);
      check("p6_clr_idx", clr_idx, 3);
      check("p6_isr", isr, 8'h08);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      check("p6_vector", dat, 8'h83);

      // Bring ISR to 0A for the vector table
      request(8'h02, 3'd1);
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      irr_pending = 8'h00;
      inta_pulse(en, dat, clr_cnt, clr_idx, leak);
      check("tbl_setup_isr", isr, 8'h0A);

      vecs[0]  = '{8'h20, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 8'h0A};
      vecs[1]  = '{8'h01, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h0A};
      vecs[2]  = '{8'h02, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h0A};
      vecs[3]  = '{8'h00, 3'd0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h08};
      vecs[4]  = '{8'h20, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08};
      vecs[5]  = '{8'h04, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1, 8'h08};
      vecs[6]  = '{8'h08, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08};
      vecs[7]  = '{8'h00, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
      vecs[8]  = '{8'h80, 3'd7, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00};
      vecs[9]  = '{8'h00, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
      vecs[10] = '{8'h00, 3'd0, 1'b1, 1'b1, 3'd5, 1'b0, 8'h00};

      for (int v = 0; v < 11; v++) begin
         irr_pending = vecs[v].irr; chosen_interrupt = vecs[v].ch;
         eoi_valid = vecs[v].eoi; eoi_specific = vecs[v].spec; eoi_level = vecs[v].elvl;
         @(posedge clk);
         #1;
         eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("tbl%0d_int", v), int_out, vecs[v].exp_int);
         check($sformatf("tbl%0d_isr", v), isr, vecs[v].exp_isr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/isr_inta_controller.md
Name: isr_inta_controller

Overview:
- Sits directly downstream of the PIC priority resolver in the 8259-style controller.
- Consumes the resolver's winning level and the masked pending IRR bits.
- Owns the In-Service Register (ISR), the INT output and the two-pulse INTA handshake (8086 mode), including vector drive.
- Handles non-specific EOI, specific EOI and automatic EOI (AEOI), and tells the IRR which bit to clear on acknowledge.

Parameters:
- INTA_SYNC, 2, number of flip-flop stages synchronising inta_n into clk (allowed values 1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irr_pending  in  8  masked IRR bits (bit 0 = IR0).
- chosen_interrupt  in  3  resolver output: index of the highest-priority pending IR.
- inta_n  in  1  CPU interrupt acknowledge, active low, asynchronous to clk.
- vector_base  in  5  T7..T3 from ICW2.
- aeoi_en  in  1  AEOI mode, from ICW4.
- eoi_valid  in  1  one-cycle OCW2 EOI strobe.
- eoi_specific  in  1  qualifies eoi_valid: 1 = specific EOI, 0 = non-specific EOI.
- eoi_level  in  3  level cleared by a specific EOI.
- int_out  out  1  interrupt request to the CPU.
- isr  out  8  In-Service Register.
- clear_irr  out  1  one-cycle pulse: IRR must clear bit clear_irr_idx.
- clear_irr_idx  out  3  index of the IRR bit to clear.
- data_out  out  8  vector byte.
- data_out_en  out  1  data bus drive enable.

Behaviour:
- Reset: all outputs are 0; state = IDLE; synchroniser stages are all 1 (inactive).
- inta_n passes through INTA_SYNC stages, then one more register for edge detection.
  - fall = previous 1, current 0. rise = previous 0, current 1.
- Priority is fully nested: a lower index is higher priority.
- hp_isr = lowest set ISR index, or 8 if the ISR is empty.
- int_out is registered, so it has 1 cycle latency:
  - int_out <= (irr_pending != 0) && (chosen_interrupt < hp_isr) && state == IDLE.
  - It deasserts on the fall that starts ACK1.
- State machine:
  - IDLE -> ACK1 on fall.
  - ACK1: latch lvl = chosen_interrupt.
    - If irr_pending[lvl] is 1: set isr[lvl], pulse clear_irr with clear_irr_idx = lvl (1 cycle).
    - If irr_pending[lvl] is 0 (spurious acknowledge): lvl = 7, no ISR set, no clear_irr.
    - ACK1 -> WAIT1 unconditionally.
  - WAIT1 -> WAIT2 on rise.
  - WAIT2 -> ACK2 on fall.
  - ACK2: data_out = {vector_base, lvl}, data_out_en = 1. Both are held while synchronised inta_n stays 0.
    - On rise: data_out_en = 0, data_out = 0.
    - If aeoi_en is set and the acknowledge was not spurious, clear isr[lvl] in the same cycle.
    - ACK2 -> IDLE on rise.
- The first INTA pulse never drives the bus.
- EOI is accepted in any state, one cycle after eoi_valid:
  - Non-specific: clear isr[hp_isr]. No effect if the ISR is empty.
  - Specific: clear isr[eoi_level].
- EOI and an ISR set in the same cycle: the EOI clear is evaluated first, then the set. A set of the same bit wins.
- Reset asserted mid-handshake: everything clears immediately (asynchronous). The next fall after release is treated as a first INTA.
- Nesting: while IR3 is in service, IR1 may raise int_out again; IR5 may not.

Decomposition:
- Shared package pic_pkg holds:
  - state enum (IDLE, ACK1, WAIT1, WAIT2, ACK2);
  - NUM_IR = 8;
  - SPURIOUS_LVL = 3'd7;
  - the hp-index function (lowest set bit, returning 8 when empty), reused by the resolver.
- One sub-module: pic_sync_edge, the INTA_SYNC-stage synchroniser plus fall/rise detect.

Test Plan:
1. irr_pending = 8'h08, chosen = 3, vector_base = 5'h10, aeoi_en = 0, two INTA pulses:
   - int_out = 1 one cycle after the request, then 0 after the first fall.
   - isr = 8'h08.
   - clear_irr pulse with clear_irr_idx = 3.
   - data_out = 8'h83 with data_out_en = 1 only during the second pulse.
2. Case 1 followed by a non-specific EOI -> isr = 8'h00, and int_out stays 0 (no request pending).
3. Same as case 1 but aeoi_en = 1 -> isr = 8'h08 between the pulses, 8'h00 on the cycle after the second rise.
4. Nesting, isr = 8'h08:
   - irr_pending = 8'h20, chosen = 5 -> int_out stays 0.
   - irr_pending = 8'h02, chosen = 1 -> int_out = 1; after the acknowledge, isr = 8'h0A.
   - Specific EOI with eoi_level = 1 -> isr = 8'h08.
5. Spurious: irr_pending drops to 0 before the first fall -> isr unchanged, no clear_irr, data_out = {vector_base, 3'b111} during the second pulse.
6. rst_n low during WAIT2:
   - Immediately: isr = 0, int_out = 0, data_out_en = 0.
   - After release, the next INTA fall is treated as ACK1 (no vector driven).
